// File: rtl/result_writeback.sv
// result_writeback: scale/truncate/activate row accumulators, pack them into 64-bit words and write them to the R region.
module result_writeback #(
    parameter int ADDR_W = 40,
    parameter int ACC_W  = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_valid_i,
    input  logic              cfg_bitwidth_i,
    input  logic [1:0]        cfg_actfun_i,
    input  logic [5:0]        cfg_a_i,
    input  logic [5:0]        cfg_k_i,
    input  logic [6:0]        cfg_m_i,
    input  logic [ADDR_W-1:0] cfg_raddr_i,
    input  logic              acc_valid_i,
    output logic              acc_ready_o,
    input  logic [ACC_W-1:0]  acc_data_i,
    input  logic              mem_req_ready_i,
    output logic              mem_req_valid_o,
    output logic [ADDR_W-1:0] mem_req_addr_o,
    output logic [4:0]        mem_req_cmd_o,
    output logic [2:0]        mem_req_typ_o,
    output logic [63:0]       mem_req_data_o,
    output logic              busy_o,
    output logic              done_o
);
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, SEND = 2'd2, DONE = 2'd3;
    logic [1:0]        state;
    logic              bw;
    logic [1:0]        act;
    logic [5:0]        a;
    logic [3:0]        p;
    logic [6:0]        m;
    logic [2:0]        lane;
    logic [6:0]        row;
    logic [ADDR_W-1:0] addr;
    logic [63:0]       pack;
    logic [ACC_W-1:0]  s;
    logic [15:0]       sub, res;
    logic              sign, over;
    logic [5:0]        sh;
    logic [3:0]        lanes_max;
    logic [63:0]       merged;
    always_comb begin
        s         = acc_data_i >> a;
        sub       = bw ? s[15:0] : {8'h00, s[7:0]};
        sign      = bw ? s[15] : s[7];
        over      = bw ? |s[ACC_W-1:15] : |s[ACC_W-1:7];
        res       = act == 2'd0 ? sub :
                    act == 2'd1 ? (sign ? 16'h0000 : sub) :
                    act == 2'd2 ? (acc_data_i[ACC_W-1] ? 16'h0000 : over ? (bw ? 16'h7fff : 16'h007f) : sub) :
                    16'h0000;
        sh        = bw ? {lane[1:0], 4'b0000} : {lane, 3'b000};
        merged    = pack | ({48'h0, res} << sh);
        lanes_max = cfg_bitwidth_i ? 4'd4 : 4'd8;
    end
    assign acc_ready_o     = state == RUN;
    assign mem_req_valid_o = state == SEND;
    assign busy_o          = state != IDLE;
    assign done_o          = state == DONE;
    assign mem_req_addr_o  = addr;
    assign mem_req_data_o  = pack;
    assign mem_req_cmd_o   = 5'b00001;
    assign mem_req_typ_o   = 3'b011;
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            bw    <= 1'b0;
            act   <= 2'd0;
            a     <= 6'd0;
            p     <= 4'd0;
            m     <= 7'd0;
            lane  <= 3'd0;
            row   <= 7'd0;
            addr  <= '0;
            pack  <= 64'h0;
        end else begin
            case (state)
                IDLE: if (cfg_valid_i) begin
                    state <= RUN;
                    bw    <= cfg_bitwidth_i;
                    act   <= cfg_actfun_i;
                    a     <= cfg_a_i;
                    p     <= (cfg_k_i != 6'd0 && cfg_k_i < {2'b00, lanes_max}) ? cfg_k_i[3:0] : lanes_max;
                    m     <= cfg_m_i;
                    lane  <= 3'd0;
                    row   <= 7'd0;
                    pack  <= 64'h0;
                    addr  <= cfg_raddr_i;
                end
                RUN: if (acc_valid_i) begin
                    pack <= merged;
                    lane <= lane + 3'd1;
                    row  <= row + 7'd1;
                    if ({1'b0, lane} == p - 4'd1 || row == m - 7'd1) state <= SEND;
                end
                SEND: if (mem_req_ready_i) begin
                    lane <= 3'd0;
                    if (row != m) begin
                        state <= RUN;
                        pack  <= 64'h0;
                        addr  <= addr + ADDR_W'(8);
                    end else begin
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_result_writeback.sv
// tb_result_writeback: directed and randomized jobs checked against an arithmetic model of rows -> packed words.
module tb_result_writeback;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cfg_valid_i = 1'b0;
    logic        cfg_bitwidth_i = 1'b0;
    logic [1:0]  cfg_actfun_i = 2'd0;
    logic [5:0]  cfg_a_i = 6'd0;
    logic [5:0]  cfg_k_i = 6'd0;
    logic [6:0]  cfg_m_i = 7'd0;
    logic [39:0] cfg_raddr_i = 40'd0;
    logic        acc_valid_i = 1'b0;
    logic        acc_ready_o;
    logic [63:0] acc_data_i = 64'd0;
    logic        mem_req_ready_i = 1'b0;
    logic        mem_req_valid_o;
    logic [39:0] mem_req_addr_o;
    logic [4:0]  mem_req_cmd_o;
    logic [2:0]  mem_req_typ_o;
    logic [63:0] mem_req_data_o;
    logic        busy_o;
    logic        done_o;

    result_writeback dut (
        .clk(clk), .reset(reset),
        .cfg_valid_i(cfg_valid_i), .cfg_bitwidth_i(cfg_bitwidth_i), .cfg_actfun_i(cfg_actfun_i),
        .cfg_a_i(cfg_a_i), .cfg_k_i(cfg_k_i), .cfg_m_i(cfg_m_i), .cfg_raddr_i(cfg_raddr_i),
        .acc_valid_i(acc_valid_i), .acc_ready_o(acc_ready_o), .acc_data_i(acc_data_i),
        .mem_req_ready_i(mem_req_ready_i), .mem_req_valid_o(mem_req_valid_o),
        .mem_req_addr_o(mem_req_addr_o), .mem_req_cmd_o(mem_req_cmd_o), .mem_req_typ_o(mem_req_typ_o),
        .mem_req_data_o(mem_req_data_o), .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [39:0] addr;
        logic [63:0] data;
    } wr_t;

    wr_t         exp_q[$];
    logic [63:0] acc_tab[64];
    int          checks = 0;
    int          failures = 0;
    bit          rand_ready = 1'b0;
    bit          ready_level = 1'b1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        mem_req_ready_i = rand_ready ? ($urandom_range(0, 3) != 0) : ready_level;
    end

    // Observes write handshakes and request stability from the negative edge.
    logic        pv = 1'b0, pr = 1'b0;
    logic [39:0] pa = 40'd0;
    logic [63:0] pd = 64'd0;
    always @(negedge clk) begin
        wr_t e;
        if (reset && mem_req_valid_o && mem_req_ready_i) begin
            if (exp_q.size() == 0) chk("unexpected_write", 64'd1, 64'd0);
            else begin
                e = exp_q.pop_front();
                chk("wr_addr", {24'd0, mem_req_addr_o}, {24'd0, e.addr});
                chk("wr_data", mem_req_data_o, e.data);
                chk("wr_cmd_typ", {56'd0, mem_req_cmd_o, mem_req_typ_o}, 64'h0b);
            end
        end
        if (reset && pv && !pr) begin
            chk("stall_valid", {63'd0, mem_req_valid_o}, 64'd1);
            chk("stall_addr", {24'd0, mem_req_addr_o}, {24'd0, pa});
            chk("stall_data", mem_req_data_o, pd);
            chk("stall_acc_ready", {63'd0, acc_ready_o}, 64'd0);
        end
        pv = reset && mem_req_valid_o;
        pr = mem_req_ready_i;
        pa = mem_req_addr_o;
        pd = mem_req_data_o;
    end

    function automatic logic [63:0] ref_res(input bit bw, input logic [1:0] act, input int a, input logic [63:0] acc);
        longint unsigned w    = bw ? 16 : 8;
        logic [63:0]     s    = acc >> a;
        logic [63:0]     half = 64'd1 << (w - 1);
        logic [63:0]     sub  = s % (64'd1 << w);
        case (act)
            2'd0:    return sub;
            2'd1:    return sub >= half ? 64'd0 : sub;
            2'd2:    return acc[63] ? 64'd0 : (s >= half ? half - 64'd1 : sub);
            default: return 64'd0;
        endcase
    endfunction

    function automatic int lanes(input bit bw, input int k);
        int n = bw ? 4 : 8;
        return (k != 0 && k < n) ? k : n;
    endfunction

    task automatic build_model(input bit bw, input logic [1:0] act, input int a, input int k, input int m, input logic [39:0] raddr);
        int          w = bw ? 16 : 8;
        int          p = lanes(bw, k);
        logic [63:0] words[64];
        wr_t         e;
        for (int i = 0; i < 64; i++) words[i] = 64'd0;
        for (int r = 0; r < m; r++) words[r / p] |= ref_res(bw, act, a, acc_tab[r]) << ((r % p) * w);
        for (int i = 0; i < (m + p - 1) / p; i++) begin
            e.addr = raddr + 40'(8 * i);
            e.data = words[i];
            exp_q.push_back(e);
        end
    endtask

    task automatic push_exp(input logic [39:0] addr, input logic [63:0] data);
        wr_t e;
        e.addr = addr;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic run_job(input bit bw, input logic [1:0] act, input int a, input int k, input int m,
                           input logic [39:0] raddr, input bit use_model, input bit gaps, input bit inject);
        int p = lanes(bw, k);
        int t;
        if (use_model) build_model(bw, act, a, k, m, raddr);
        @(posedge clk); #1;
        cfg_bitwidth_i = bw; cfg_actfun_i = act; cfg_a_i = 6'(a); cfg_k_i = 6'(k);
        cfg_m_i = 7'(m); cfg_raddr_i = raddr; cfg_valid_i = 1'b1;
        @(posedge clk); #1;
        cfg_valid_i = 1'b0;
        for (int r = 0; r < m; r++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                acc_valid_i = 1'b0;
                @(posedge clk); #1;
            end
            acc_valid_i = 1'b1;
            acc_data_i  = acc_tab[r];
            if (inject && r == 1) begin
                cfg_valid_i = 1'b1; cfg_bitwidth_i = ~bw; cfg_actfun_i = 2'($urandom);
                cfg_a_i = 6'($urandom); cfg_k_i = 6'($urandom); cfg_m_i = 7'($urandom_range(1, 64));
                cfg_raddr_i = 40'h7f_0000_0000;
            end
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!acc_ready_o && t < 400);
            if (!acc_ready_o) chk("acc_timeout", 64'd0, 64'd1);
            @(posedge clk); #1;
            acc_valid_i = 1'b0;
            cfg_valid_i = 1'b0;
            if (r % p == p - 1 || r == m - 1) begin
                @(negedge clk);
                chk("req_latency", {63'd0, mem_req_valid_o}, 64'd1);
            end
        end
        t = 0;
        while (!done_o && t < 400) begin
            @(negedge clk);
            t++;
        end
        chk("done_seen", {63'd0, done_o}, 64'd1);
        chk("writes_left", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        @(negedge clk);
        chk("done_pulse_busy", {62'd0, done_o, busy_o}, 64'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ctl", {60'd0, acc_ready_o, mem_req_valid_o, busy_o, done_o}, 64'd0);
        chk("rst_addr", {24'd0, mem_req_addr_o}, 64'd0);
        chk("rst_data", mem_req_data_o, 64'd0);
        chk("rst_cmd_typ", {56'd0, mem_req_cmd_o, mem_req_typ_o}, 64'h0b);
        @(posedge clk); #1;
        reset = 1'b1;

        for (int i = 0; i < 5; i++) acc_tab[i] = 64'(i + 1);
        push_exp(40'h30, 64'h0000000504030201);
        run_job(1'b0, 2'd0, 0, 5, 5, 40'h30, 1'b0, 1'b0, 1'b0);

        acc_tab[0] = 64'h10; acc_tab[1] = 64'h80000; acc_tab[2] = 64'hFFF0; acc_tab[3] = 64'h20;
        push_exp(40'h40, 64'h00020FFF00000001);
        run_job(1'b1, 2'd1, 4, 0, 4, 40'h40, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 10; i++) acc_tab[i] = 64'(i);
        push_exp(40'h100, 64'h0706050403020100);
        push_exp(40'h108, 64'h0000000000000908);
        run_job(1'b0, 2'd0, 0, 0, 10, 40'h100, 1'b0, 1'b0, 1'b0);

        acc_tab[0] = 64'h1FF; acc_tab[1] = 64'hFFFFFFFFFFFFFF80; acc_tab[2] = 64'h05;
        push_exp(40'h200, 64'h000000000005007F);
        run_job(1'b0, 2'd2, 0, 0, 3, 40'h200, 1'b0, 1'b0, 1'b0);

        // Backpressure: the request must hold for at least 10 cycles with ready low.
        for (int i = 0; i < 5; i++) acc_tab[i] = 64'(i + 1);
        push_exp(40'h38, 64'h0000000504030201);
        ready_level = 1'b0;
        fork
            run_job(1'b0, 2'd0, 0, 5, 5, 40'h38, 1'b0, 1'b0, 1'b0);
            begin
                int t = 0;
                while (!mem_req_valid_o && t < 200) begin
                    @(negedge clk);
                    t++;
                end
                chk("bp_valid_seen", {63'd0, mem_req_valid_o}, 64'd1);
                repeat (10) @(negedge clk);
                chk("bp_pending", 64'(exp_q.size()), 64'd1);
                ready_level = 1'b1;
            end
        join

        // Reset in the middle of RUN: outputs clear and nothing is written.
        @(posedge clk); #1;
        cfg_bitwidth_i = 1'b0; cfg_actfun_i = 2'd0; cfg_a_i = 6'd0; cfg_k_i = 6'd0;
        cfg_m_i = 7'd10; cfg_raddr_i = 40'h500; cfg_valid_i = 1'b1;
        @(posedge clk); #1;
        cfg_valid_i = 1'b0; acc_valid_i = 1'b1; acc_data_i = 64'd7;
        @(negedge clk);
        chk("ready_after_cfg", {63'd0, acc_ready_o}, 64'd1);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0; acc_valid_i = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_ctl", {60'd0, acc_ready_o, mem_req_valid_o, busy_o, done_o}, 64'd0);
        chk("mid_rst_addr", {24'd0, mem_req_addr_o}, 64'd0);
        chk("mid_rst_data", mem_req_data_o, 64'd0);
        repeat (20) @(negedge clk);
        chk("mid_rst_idle", {62'd0, busy_o, mem_req_valid_o}, 64'd0);

        for (int j = 0; j < 6; j++) acc_tab[j] = 64'(j * 3 + 1);
        run_job(1'b0, 2'd0, 0, 3, 6, 40'h600, 1'b1, 1'b0, 1'b1);

        rand_ready = 1'b1;
        for (int i = 0; i < 25; i++) begin
            bit          bw = 1'($urandom);
            logic [1:0]  act = 2'($urandom);
            int          a = $urandom_range(0, 24);
            int          k = $urandom_range(0, 10);
            int          m = (i % 6 == 0) ? 1 : $urandom_range(1, 64);
            logic [39:0] ra = {$urandom, $urandom} & 40'hFF_FFFF_FFF8;
            for (int r = 0; r < 64; r++) acc_tab[r] = {$urandom, $urandom} >> $urandom_range(0, 63);
            run_job(bw, act, a, k, m, ra, 1'b1, 1'b1, (i % 5 == 0) && m > 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/result_writeback.md
# result_writeback

Back-end stage of the matrix-vector accelerator, between the row-accumulator datapath and the external memory request port. It takes one 64-bit dot-product accumulator per result row and processes each one in turn: arithmetic scaling by the shift `a`, truncation to the element width, then the activation function. It packs the results `k'` elements per 64-bit word and issues each full or final word as a doubleword write to the R region. When all `M` rows are committed it raises a done pulse, which the command unit turns into the RoCC response.

## Interface

Parameters:
- `ADDR_W`, 40, memory address width
- `ACC_W`, 64, accumulator width

Ports:
- `clk`  input  1  clock
- `reset`  input  1  synchronous, active-low reset
- `cfg_valid_i`  input  1  one-cycle pulse: latch configuration and start a job (honoured only in IDLE)
- `cfg_bitwidth_i`  input  1  0 = 8-bit elements, 1 = 16-bit elements
- `cfg_actfun_i`  input  2  0 = SWS, 1 = ReLU, 2 = saturating ReLU, 3 = reserved
- `cfg_a_i`  input  6  right-shift amount, 0-24
- `cfg_k_i`  input  6  elements per word (`k'`); 0 = full word
- `cfg_m_i`  input  7  row count, 1-64
- `cfg_raddr_i`  input  ADDR_W  R base address, 8-byte aligned
- `acc_valid_i`  input  1  accumulator available
- `acc_ready_o`  output  1  stage accepts accumulator
- `acc_data_i`  input  ACC_W  row accumulator, rows delivered in order 0..M-1
- `mem_req_ready_i`  input  1  memory accepts request
- `mem_req_valid_o`  output  1  write request valid
- `mem_req_addr_o`  output  ADDR_W  write address
- `mem_req_cmd_o`  output  5  constant `5'b00001` (write)
- `mem_req_typ_o`  output  3  constant `3'b011` (doubleword)
- `mem_req_data_o`  output  64  packed word
- `busy_o`  output  1  high whenever state is not IDLE
- `done_o`  output  1  one-cycle pulse after the last write handshake

## Operation

- **Element width and packing**
  - Element width `W` = 8 or 16.
  - Lanes per word `P` = `k' ? min(k', 64/W) : 64/W`.
  - Row `r` lands in word `r / P`, at lane `r % P`, bits `[(r%P)*W +: W]`.
  - Write address = `raddr + 8*(r/P)`.
  - Unused lanes are written as zero.
- **Arithmetic per accumulator**
  - `s = acc >> a` (logical shift, 64-bit); `sub = s[W-1:0]`.
  - SWS: result = `sub`.
  - ReLU: result = `sub[W-1] ? 0 : sub`.
  - Saturating ReLU: result = 0 if `acc[63]`; else `2^(W-1)-1` if `s[63:W-1]` is nonzero; else `sub`.
  - Reserved (3): result = 0.
- **States**
  - IDLE → RUN on `cfg_valid_i`. The configuration registers are latched, the lane/row counters are cleared and the pack register is zeroed.
  - RUN: `acc_ready_o = 1`. Each handshake writes the result into the current lane and advances the lane and row counters. When the lane reaches `P-1`, or the row reaches `M-1`, the next state is SEND.
  - SEND: `mem_req_valid_o = 1`; address, data and commands are held stable. `acc_ready_o = 0`.
    - On `mem_req_ready_i`, if rows remain: → RUN, with the pack register zeroed and the word address incremented by 8.
    - Otherwise: → DONE.
  - DONE: `done_o = 1` for one cycle, then → IDLE.
- **Boundary rules**
  - `cfg_valid_i` outside IDLE is ignored.
  - `acc_valid_i` outside RUN is not accepted.
  - `M` not a multiple of `P` flushes a partial final word.
  - `M = 1` yields exactly one write.
  - `a` > 63 cannot occur; the port is 6 bits wide.

## Timing

- **Reset values:** `acc_ready_o` 0, `mem_req_valid_o` 0, `mem_req_addr_o` 0, `mem_req_data_o` 0, `busy_o` 0, `done_o` 0, state IDLE. `mem_req_cmd_o` and `mem_req_typ_o` are constants.
- Reset asserted mid-job forces IDLE at the next edge. Any pending request is dropped and no further writes issue.
- `acc_ready_o` is high in the first cycle after the `cfg_valid_i` edge.
- `mem_req_valid_o` rises in the cycle after the handshake that completes a word.
- Latency from the last element of a word to the request is 1 cycle.
- The request is held for any number of cycles while `mem_req_ready_i` is low.
- After a write handshake, RUN resumes the next cycle. Sustained throughput is P accumulators per P+1 cycles when memory is always ready.
- `done_o` is asserted in the cycle after the final write handshake. `busy_o` falls in the cycle after that.
- Arithmetic is combinational on `acc_data_i`, registered into the pack register at the handshake edge. No other pipeline stages.

## Test plan

- **8-bit packing and flush:** 8-bit, SWS, a=0, k'=5, M=5, raddr=0x30, accs 1..5.
  - Required: one write, addr 0x30, data `0x0000000504030201`, then `done_o` pulse.
- **16-bit ReLU with shift:** 16-bit, ReLU, a=4, k'=0, M=4, accs 0x10, 0x80000, 0xFFF0, 0x20.
  - Required: data `0x00020FFF00000001`.
- **Two words, partial tail:** 8-bit, SWS, k'=0, M=10, raddr=0x100, accs 0..9.
  - Required: writes at 0x100 (`0x0706050403020100`) and 0x108 (`0x0000000000000908`), in order.
- **Saturating ReLU:** 8-bit, act=2, a=0, M=3, accs 0x1FF, 0xFFFFFFFFFFFFFF80, 0x05.
  - Required: data `0x000000000005007F`.
- **Backpressure:** hold `mem_req_ready_i` low for 10 cycles during SEND.
  - Required: valid, addr and data unchanged; `acc_ready_o` stays 0; exactly one write after ready rises.
- **Reset and ignored config:**
  - Pulse reset low mid-RUN. Required: all outputs return to reset values and no writes occur.
  - Issue `cfg_valid_i` while busy. Required: it is ignored.
